// File: rtl/uart_txd_fifo.sv
// uart_txd_fifo: 8N1 UART transmitter (LSB first) fed by a circular byte FIFO.
// The FSM pops straight from STOP into START so queued frames go out with no idle gap.
//
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | start bit (low) for BIT_WIDTH cycles
//   DATA  | eight data bits, LSB first, BIT_WIDTH cycles each
//   STOP  | STOP_BITS stop bits (high), then pop next byte or return to IDLE
module uart_txd_fifo #(
  parameter int BIT_WIDTH  = 5208,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk50M,
  input  logic                        rst,
  input  logic [7:0]                  txd_data,
  input  logic                        txd_en,
  output logic                        txd_ready,
  output logic                        txd_pin,
  output logic                        txd_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_d;
  logic [15:0]     cyc_cnt, cyc_cnt_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic            stop_cnt, stop_cnt_d;
  logic [7:0]      shift, shift_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_d;
  logic            pop;
  logic            wr_acc;
  logic            bit_end;

  assign bit_end = (cyc_cnt == 16'(BIT_WIDTH - 1));
  // Acceptance looks at the registered count, so a write on a pop-from-full edge is dropped.
  assign wr_acc  = txd_en && (fifo_count < DEPTH_C);
  assign count_d = fifo_count + CW'(wr_acc) - CW'(pop);

  always_comb begin
    state_d    = state;
    cyc_cnt_d  = bit_end ? 16'd0 : cyc_cnt + 16'd1;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    shift_d    = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        cyc_cnt_d = 16'd0;
        if (fifo_count != '0) begin
          pop        = 1'b1;
          shift_d    = mem[rd_ptr];
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            stop_cnt_d = 1'b0;
            state_d    = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            if (fifo_count != '0) begin
              pop        = 1'b1;
              shift_d    = mem[rd_ptr];
              bit_cnt_d  = 3'd0;
              stop_cnt_d = 1'b0;
              state_d    = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state      <= IDLE;
      cyc_cnt    <= 16'd0;
      bit_cnt    <= 3'd0;
      stop_cnt   <= 1'b0;
      shift      <= 8'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      txd_pin    <= 1'b1;
      txd_busy   <= 1'b0;
      txd_ready  <= 1'b1;
    end else begin
      state      <= state_d;
      cyc_cnt    <= cyc_cnt_d;
      bit_cnt    <= bit_cnt_d;
      stop_cnt   <= stop_cnt_d;
      shift      <= shift_d;
      fifo_count <= count_d;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      // Line level follows the current state, so it trails the FSM by one cycle.
      case (state)
        START:   txd_pin <= 1'b0;
        DATA:    txd_pin <= shift[0];
        default: txd_pin <= 1'b1;
      endcase
      txd_busy  <= (state != IDLE) || (state_d != IDLE) || (count_d != '0);
      txd_ready <= (count_d < DEPTH_C);
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk50M) begin
    if (wr_acc) mem[wr_ptr] <= txd_data;
  end

endmodule

// File: tb/tb_uart_txd_fifo.sv
// tb_uart_txd_fifo: directed checks of framing, FIFO full/drop behaviour,
// mid-frame reset, two stop bits and a 9600-baud frame against hand-computed values.
module tb_uart_txd_fifo;

  logic clk50M = 1'b0;
  always #10 clk50M = ~clk50M;

  int cyc = 0;
  always @(posedge clk50M) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic       rst1, en1, ready1, pin1, busy1;
  logic [7:0] data1;
  logic [2:0] count1;
  logic       rst2, en2, ready2, pin2, busy2;
  logic [7:0] data2;
  logic [2:0] count2;
  logic       rst3, en3, ready3, pin3, busy3;
  logic [7:0] data3;
  logic [2:0] count3;

  uart_txd_fifo #(.BIT_WIDTH(8), .FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .clk50M(clk50M), .rst(rst1), .txd_data(data1), .txd_en(en1),
    .txd_ready(ready1), .txd_pin(pin1), .txd_busy(busy1), .fifo_count(count1));

  uart_txd_fifo #(.BIT_WIDTH(8), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk50M(clk50M), .rst(rst2), .txd_data(data2), .txd_en(en2),
    .txd_ready(ready2), .txd_pin(pin2), .txd_busy(busy2), .fifo_count(count2));

  uart_txd_fifo #(.BIT_WIDTH(5208), .FIFO_DEPTH(4), .STOP_BITS(1)) dut3 (
    .clk50M(clk50M), .rst(rst3), .txd_data(data3), .txd_en(en3),
    .txd_ready(ready3), .txd_pin(pin3), .txd_busy(busy3), .fifo_count(count3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic pin_of(input int which);
    case (which)
      1:       return pin1;
      2:       return pin2;
      default: return pin3;
    endcase
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk50M);
  endtask

  // Called at a negedge; the byte is taken on the following posedge, returned as e.
  task automatic wr(input int which, input logic [7:0] b, output int e);
    case (which)
      1:       begin en1 = 1'b1; data1 = b; end
      2:       begin en2 = 1'b1; data2 = b; end
      default: begin en3 = 1'b1; data3 = b; end
    endcase
    e = cyc + 1;
    @(negedge clk50M);
    en1 = 1'b0;
    en2 = 1'b0;
    en3 = 1'b0;
  endtask

  task automatic wait_fall(input int which, input int limit, output int t0, output bit ok);
    int i;
    i  = 0;
    ok = 1'b0;
    t0 = 0;
    while (!ok && i < limit) begin
      if (pin_of(which) == 1'b0) begin
        ok = 1'b1;
        t0 = cyc;
      end else begin
        @(negedge clk50M);
        i++;
      end
    end
  endtask

  // Reference receiver: mid-bit sampling, stop bit must read high.
  task automatic rx_decode(input int which, input int bw, output logic [7:0] b,
                           output int t0, output bit ok);
    b = 8'h00;
    wait_fall(which, 2000, t0, ok);
    if (ok) begin
      for (int k = 0; k < 8; k++) begin
        wait_until(t0 + bw * (1 + k) + bw / 2);
        b[k] = pin_of(which);
      end
      wait_until(t0 + 9 * bw + bw / 2);
      if (pin_of(which) != 1'b1) ok = 1'b0;
    end
  endtask

  // Checks the first and last cycle of each of the ten levels and decodes mid-bit.
  task automatic frame_check(input int which, input int t0, input int bw,
                             input logic [9:0] lvls, output logic [7:0] mb);
    mb = 8'h00;
    for (int i = 0; i < 10; i++) begin
      wait_until(t0 + bw * i);
      check_eq($sformatf("w%0d_lvl%0d_first", which, i), 32'(pin_of(which)), 32'(lvls[i]));
      wait_until(t0 + bw * i + bw / 2);
      if (i >= 1 && i <= 8) mb[i-1] = pin_of(which);
      wait_until(t0 + bw * i + bw - 1);
      check_eq($sformatf("w%0d_lvl%0d_last", which, i), 32'(pin_of(which)), 32'(lvls[i]));
    end
  endtask

  logic [7:0] rx_b[$];
  int         rx_t[$];
  bit         rx_ok[$];

  initial begin
    #1800000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         e, e2, t0, bad;
    bit         ok;
    logic [7:0] mb;
    logic [7:0] exp_b [7];
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h08, 8'h0A};

    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    data1 = 8'h00; data2 = 8'h00; data3 = 8'h00;
    repeat (3) @(negedge clk50M);
    check_eq("rst_pin",   32'(pin1),   32'd1);
    check_eq("rst_count", 32'(count1), 32'd0);
    check_eq("rst_busy",  32'(busy1),  32'd0);
    check_eq("rst_ready", 32'(ready1), 32'd1);
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;

    // Single byte 0xA5: start low two edges after the write, busy drops with the line frame.
    wait_until(9);
    wr(1, 8'hA5, e);
    check_eq("a_count_after_wr", 32'(count1), 32'd1);
    check_eq("a_busy_after_wr",  32'(busy1),  32'd1);
    check_eq("a_pin_after_wr",   32'(pin1),   32'd1);
    wait_until(e + 1);
    check_eq("a_count_after_pop", 32'(count1), 32'd0);
    check_eq("a_pin_at_pop",      32'(pin1),   32'd1);
    frame_check(1, e + 2, 8, {1'b1, 8'hA5, 1'b0}, mb);
    check_eq("a_decoded", 32'(mb), 32'hA5);
    wait_until(e + 81);
    check_eq("a_busy_last", 32'(busy1), 32'd1);
    wait_until(e + 82);
    check_eq("a_busy_fall", 32'(busy1), 32'd0);

    // Fill while the first frame runs, drop on full, write on pop edges.
    repeat (4) @(negedge clk50M);
    wr(1, 8'h01, e);
    fork
      begin
        logic [7:0] rb;
        int         rt;
        bit         rok;
        for (int f = 0; f < 7; f++) begin
          rx_decode(1, 8, rb, rt, rok);
          rx_b.push_back(rb);
          rx_t.push_back(rt);
          rx_ok.push_back(rok);
          if (!rok) break;
        end
      end
    join_none
    wait_until(e + 2);
    wr(1, 8'h02, e2);
    check_eq("b_count_1", 32'(count1), 32'd1);
    wr(1, 8'h03, e2);
    check_eq("b_count_2", 32'(count1), 32'd2);
    wr(1, 8'h04, e2);
    check_eq("b_ready_3", 32'(ready1), 32'd1);
    wr(1, 8'h05, e2);
    check_eq("b_count_full", 32'(count1), 32'd4);
    check_eq("b_ready_full", 32'(ready1), 32'd0);
    wr(1, 8'h06, e2);
    check_eq("b_count_drop", 32'(count1), 32'd4);
    check_eq("b_ready_drop", 32'(ready1), 32'd0);
    wait_until(e + 80);
    check_eq("b_count_pre_pop1", 32'(count1), 32'd4);
    wr(1, 8'h07, e2);
    check_eq("b_count_popfull_wr", 32'(count1), 32'd3);
    check_eq("b_ready_popfull",    32'(ready1), 32'd1);
    wr(1, 8'h08, e2);
    check_eq("b_count_refill", 32'(count1), 32'd4);
    check_eq("b_ready_refill", 32'(ready1), 32'd0);
    wait_until(e + 160);
    wr(1, 8'h09, e2);
    check_eq("b_count_popfull_wr2", 32'(count1), 32'd3);
    wait_until(e + 240);
    check_eq("b_count_pre_pop3", 32'(count1), 32'd3);
    wr(1, 8'h0A, e2);
    check_eq("b_count_pop_wr", 32'(count1), 32'd3);
    check_eq("b_ready_pop_wr", 32'(ready1), 32'd1);
    while (rx_b.size() < 7 && cyc < e + 700) @(negedge clk50M);
    check_eq("b_frames", 32'(rx_b.size()), 32'd7);
    for (int f = 0; f < rx_b.size() && f < 7; f++) begin
      check_eq($sformatf("b_byte%0d", f),  32'(rx_b[f]),  32'(exp_b[f]));
      check_eq($sformatf("b_start%0d", f), 32'(rx_t[f]),  32'(e + 2 + 80 * f));
      check_eq($sformatf("b_stop%0d", f),  32'(rx_ok[f]), 32'd1);
    end
    wait_until(e + 561);
    check_eq("b_busy_last", 32'(busy1), 32'd1);
    wait_until(e + 562);
    check_eq("b_busy_fall", 32'(busy1), 32'd0);

    // Reset during data bit 3 with a second byte still queued.
    repeat (4) @(negedge clk50M);
    wr(1, 8'hC3, e);
    wr(1, 8'h3C, e2);
    t0 = e + 2;
    wait_until(t0 + 34);
    check_eq("c_pin_bit3",   32'(pin1),   32'd0);
    check_eq("c_count_pre",  32'(count1), 32'd1);
    rst1 = 1'b1;
    @(negedge clk50M);
    rst1 = 1'b0;
    check_eq("c_pin_rst",   32'(pin1),   32'd1);
    check_eq("c_count_rst", 32'(count1), 32'd0);
    check_eq("c_busy_rst",  32'(busy1),  32'd0);
    check_eq("c_ready_rst", 32'(ready1), 32'd1);
    bad = 0;
    repeat (200) begin
      @(negedge clk50M);
      if (pin1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    check_eq("c_quiet_after_rst", 32'(bad), 32'd0);

    // Two stop bits: 0xFF then 0x00 back to back, 88-cycle frame.
    wr(2, 8'hFF, e);
    wr(2, 8'h00, e2);
    t0 = e + 2;
    wait_until(t0);
    check_eq("d_start_first", 32'(pin2), 32'd0);
    wait_until(t0 + 7);
    check_eq("d_start_last", 32'(pin2), 32'd0);
    bad = 0;
    for (int t = 8; t < 88; t++) begin
      wait_until(t0 + t);
      if (pin2 !== 1'b1) bad++;
    end
    check_eq("d_high_run", 32'(bad), 32'd0);
    wait_until(t0 + 88);
    check_eq("d_next_start", 32'(pin2), 32'd0);
    wait_until(t0 + 175);
    check_eq("d_stop2_last", 32'(pin2),  32'd1);
    check_eq("d_busy_last",  32'(busy2), 32'd1);
    wait_until(t0 + 176);
    check_eq("d_busy_fall",  32'(busy2), 32'd0);

    // 9600 baud at 50 MHz: 0x55, every level exactly 5208 cycles.
    @(negedge clk50M);
    wr(3, 8'h55, e);
    wait_fall(3, 10, t0, ok);
    check_eq("e_fall_seen", 32'(ok), 32'd1);
    check_eq("e_fall_time", 32'(t0), 32'(e + 2));
    frame_check(3, e + 2, 5208, {1'b1, 8'h55, 1'b0}, mb);
    check_eq("e_decoded", 32'(mb), 32'h55);
    wait_until(e + 2 + 52080);
    check_eq("e_busy_fall", 32'(busy3), 32'd0);
    check_eq("e_pin_idle",  32'(pin3),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
